argmax_chunk_packer: RTL

ARGMAX_CHUNK_PACKER -- requirements
Module: argmax_chunk_packer

---
 rtl/argmax_pkg.sv | 15 +
 rtl/chunk_fill_register.sv | 45 ++++
 rtl/argmax_chunk_packer.sv | 107 ++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared constants and FSM encoding for the argmax chunk packer.
// Lane geometry matches the downstream 16-input serial argmax.
package argmax_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 4;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/chunk_fill_register.sv
// 16-lane write-by-index register; idle lanes sit at PAD.
// chunk shows the register merged with this cycle's write.
module chunk_fill_register
  import argmax_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [LANE_W-1:0]       wr_idx,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    flush,
  output logic signed [WIDTH-1:0] chunk [LANES]
);

  localparam logic signed [WIDTH-1:0] PAD =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] lanes [LANES];

  // A flushing write is consumed through chunk, so lanes go back to PAD.
  always_ff @(posedge clk) begin
    if (rst || clear || (wr_en && flush)) begin
      for (int i = 0; i < LANES; i++) begin
        lanes[i] <= PAD;
      end
    end else if (wr_en) begin
      lanes[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      chunk[i] = lanes[i];
      if (wr_en && (LANE_W'(i) == wr_idx)) begin
        chunk[i] = wr_data;
      end else if (wr_en && (LANE_W'(i) > wr_idx)) begin
        chunk[i] = PAD;
      end
    end
  end

endmodule

// File: rtl/argmax_chunk_packer.sv
// Packs a scalar score stream into padded 16-lane chunks and
// sequences clear/enable/done for a serial 16-input argmax.
module argmax_chunk_packer
  import argmax_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter int CHUNK_COUNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic signed [WIDTH-1:0] out [LANES],
  output logic                    out_enable,
  output logic                    out_clear,
  output logic                    frame_done,
  output logic                    frame_overflow
);

  localparam logic signed [WIDTH-1:0] PAD =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CHUNK_COUNT_WIDTH-1:0] CNT_MAX =
    {CHUNK_COUNT_WIDTH{1'b1}};
  localparam logic [LANE_W-1:0] LANE_TOP =
    LANE_W'(LANES - 1);

  state_t                       state;
  logic [LANE_W-1:0]            lane;
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_cnt;
  logic                         first_seen;
  logic                         accept;
  logic                         emit;
  logic signed [WIDTH-1:0]      chunk [LANES];

  assign in_ready   = (state == S_FILL);
  assign out_clear  = (state == S_CLEAR);
  assign frame_done = (state == S_DONE);

  assign accept = in_valid && in_ready;
  assign emit   = accept && (in_last || (lane == LANE_TOP));

  chunk_fill_register #(
    .WIDTH (WIDTH)
  ) u_fill (
    .clk     (clk),
    .rst     (rst),
    .clear   (out_clear),
    .wr_en   (accept),
    .wr_idx  (lane),
    .wr_data (in_data),
    .flush   (emit),
    .chunk   (chunk)
  );

  // chunk_cnt counts chunks after the first, so a saturated counter
  // on a new emit means the frame passed 2^CHUNK_COUNT_WIDTH chunks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_CLEAR;
      lane           <= '0;
      chunk_cnt      <= '0;
      first_seen     <= 1'b0;
      frame_overflow <= 1'b0;
      out_enable     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        out[i] <= PAD;
      end
    end else begin
      out_enable <= emit;
      if (emit) begin
        for (int i = 0; i < LANES; i++) begin
          out[i] <= chunk[i];
        end
        if (!first_seen) begin
          first_seen <= 1'b1;
        end else if (chunk_cnt == CNT_MAX) begin
          frame_overflow <= 1'b1;
        end else begin
          chunk_cnt <= chunk_cnt + 1'b1;
        end
      end
      unique case (state)
        S_CLEAR: begin
          state          <= S_FILL;
          lane           <= '0;
          chunk_cnt      <= '0;
          first_seen     <= 1'b0;
          frame_overflow <= 1'b0;
        end
        S_FILL: begin
          if (accept) begin
            lane <= in_last ? '0 : lane + 1'b1;
            if (in_last) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_CLEAR;
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
